// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding an LSB-first serializer.
// Back-to-back queued bytes leave the pin as contiguous frames with no idle gap.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk_from_FPGA,
    input  logic       rst_from_FPGA,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       tx_busy,
    output logic       overflow,
    output logic       uart_tx_pin_for_FPGA
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              line_q, line_d;
    logic              busy_q, busy_d;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic              push;
    logic              pop;
    logic              baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);

    // Transmit FSM: next state, baud/bit counters, shift register and pop request.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    baud_d  = '0;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d   = S_DATA;
                    baud_d    = '0;
                    bit_idx_d = '0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    // A queued byte chains straight into the next start bit.
                    if (!empty_q) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
            end
        endcase

        if (pop) begin
            shift_d = fifo_mem[rd_ptr_q];
        end

        // Pin level follows the state being entered so the line is a plain flop.
        case (state_d)
            S_START: line_d = 1'b0;
            S_DATA:  line_d = shift_d[0];
            default: line_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; flags reflect the count after this edge.
    always_comb begin
        push     = wr_en && !full_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        full_d     = (count_d == CNT_FULL);
        empty_d    = (count_d == '0);
        overflow_d = overflow_q | (wr_en & full_q);
    end

    always_ff @(posedge clk_from_FPGA) begin
        if (rst_from_FPGA) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            line_q     <= 1'b1;
            busy_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array carries no reset; pointers and count define its contents.
    always_ff @(posedge clk_from_FPGA) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    assign fifo_full            = full_q;
    assign fifo_empty           = empty_q;
    assign tx_busy              = busy_q;
    assign overflow             = overflow_q;
    assign uart_tx_pin_for_FPGA = line_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Status vectors are {line, busy, empty, full, overflow}.
module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_full, fifo_empty, tx_busy, overflow, line;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk_from_FPGA        (clk),
        .rst_from_FPGA        (rst),
        .wr_en                (wr_en),
        .wr_data              (wr_data),
        .fifo_full            (fifo_full),
        .fifo_empty           (fifo_empty),
        .tx_busy              (tx_busy),
        .overflow             (overflow),
        .uart_tx_pin_for_FPGA (line)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         start;
        logic       stop_ok;
    } rx_t;
    rx_t rx_q[$];

    typedef struct {
        int         off;
        logic [4:0] st;
    } vec_t;
    vec_t tv[$];

    // Frame decoder on the pin; aborts on reset so truncated frames are never logged.
    logic       mon_active = 1'b0;
    int         mon_off    = 0;
    int         mon_start  = 0;
    logic [7:0] mon_sh     = 8'h00;
    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (line === 1'b0) begin
                    mon_active = 1'b1;
                    mon_off    = 0;
                    mon_start  = cyc;
                    mon_sh     = 8'h00;
                end
            end else begin
                mon_off++;
                if ((mon_off % CPB) == 1 && mon_off >= 5 && mon_off <= 33)
                    mon_sh = {line, mon_sh[7:1]};
                else if (mon_off == 37)
                    rx_q.push_back('{mon_sh, mon_start, line === 1'b1});
                if (mon_off == 39) mon_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0] st();
        return {line, tx_busy, fifo_empty, fifo_full, overflow};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("rx_frame_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        tick();
        check("reset_apply", 32'(st()), 32'(5'b10100));
        tick();
        rst = 1'b0;
        rx_q.delete();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin : main
        int e;
        int bad;
        logic [7:0] exp_b [$];

        // 0xA5 frame checkpoints, hand-derived: bits LSB first 1,0,1,0,0,1,0,1.
        tv.push_back('{0,  5'b10000});
        tv.push_back('{1,  5'b01100});
        tv.push_back('{4,  5'b01100});
        tv.push_back('{5,  5'b11100});
        tv.push_back('{8,  5'b11100});
        tv.push_back('{9,  5'b01100});
        tv.push_back('{12, 5'b01100});
        tv.push_back('{13, 5'b11100});
        tv.push_back('{16, 5'b11100});
        tv.push_back('{17, 5'b01100});
        tv.push_back('{20, 5'b01100});
        tv.push_back('{21, 5'b01100});
        tv.push_back('{24, 5'b01100});
        tv.push_back('{25, 5'b11100});
        tv.push_back('{28, 5'b11100});
        tv.push_back('{29, 5'b01100});
        tv.push_back('{32, 5'b01100});
        tv.push_back('{33, 5'b11100});
        tv.push_back('{36, 5'b11100});
        tv.push_back('{37, 5'b11100});
        tv.push_back('{40, 5'b11100});
        tv.push_back('{41, 5'b10100});

        // Reset state and 50 quiet cycles.
        tick();
        tick();
        check("reset_state", 32'(st()), 32'(5'b10100));
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (st() !== 5'b10100) bad++;
        end
        check("idle_50_cycles_bad", 32'(bad), 32'd0);

        // Single 0xA5 frame against the checkpoint table.
        write_byte(8'hA5);
        e = cyc;
        for (int i = 0; i < tv.size(); i++) begin
            wait_until(e + tv[i].off);
            check($sformatf("a5_frame_off%0d", tv[i].off), 32'(st()), 32'(tv[i].st));
        end
        repeat (5) tick();
        rx_q.delete();

        // Two bytes on consecutive cycles: contiguous frames.
        write_byte(8'h55);
        e = cyc;
        write_byte(8'h0F);
        wait_until(e + 40);
        check("b2b_last_stop", 32'(st()), 32'(5'b11000));
        wait_until(e + 41);
        check("b2b_second_start", 32'(st()), 32'(5'b01100));
        wait_rx(2, 120);
        if (rx_q.size() >= 2) begin
            check("b2b_byte0", 32'(rx_q[0].data), 32'h55);
            check("b2b_byte1", 32'(rx_q[1].data), 32'h0F);
            check("b2b_start0", 32'(rx_q[0].start), 32'(e + 1));
            check("b2b_gap", 32'(rx_q[1].start - rx_q[0].start), 32'd40);
            check("b2b_stop_ok", 32'({rx_q[0].stop_ok, rx_q[1].stop_ok}), 32'b11);
        end
        wait_until(e + 80);
        check("b2b_end_busy", 32'(st()), 32'(5'b11100));
        wait_until(e + 81);
        check("b2b_idle", 32'(st()), 32'(5'b10100));
        repeat (5) tick();
        rx_q.delete();

        // Six writes into a depth-4 FIFO: sixth dropped.
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h11 * (i + 1));
            tick();
            if (i == 4) check("ovf_full_before_drop", 32'(st()), 32'(5'b01010));
            if (i == 5) check("ovf_after_drop", 32'(st()), 32'(5'b11011));
        end
        wr_en = 1'b0;
        wait_rx(5, 260);
        repeat (60) tick();
        check("ovf_frames_total", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check($sformatf("ovf_byte%0d", i), 32'(rx_q[i].data), 32'(exp_b[i]));
            check($sformatf("ovf_stop%0d", i), 32'(rx_q[i].stop_ok), 32'd1);
        end
        check("ovf_sticky_end", 32'(st()), 32'(5'b10101));

        // Write while full on the exact STOP->START pop edge.
        do_reset();
        write_byte(8'hC1);
        e = cyc;
        write_byte(8'h3C);
        write_byte(8'h81);
        write_byte(8'h7E);
        write_byte(8'h99);
        wait_until(e + 40);
        check("pop_edge_pre", 32'(st()), 32'(5'b11010));
        write_byte(8'hEE);
        check("pop_edge_drop", 32'(st()), 32'(5'b01001));
        write_byte(8'h5A);
        check("pop_edge_count3", 32'(st()), 32'(5'b01011));
        exp_b = '{8'hC1, 8'h3C, 8'h81, 8'h7E, 8'h99, 8'h5A};
        wait_rx(6, 300);
        for (int i = 0; i < 6 && i < rx_q.size(); i++)
            check($sformatf("pop_edge_byte%0d", i), 32'(rx_q[i].data), 32'(exp_b[i]));
        repeat (10) tick();

        // Reset during data bit 3 with two bytes still queued.
        do_reset();
        write_byte(8'h12);
        e = cyc;
        write_byte(8'h34);
        write_byte(8'h56);
        wait_until(e + 17);
        check("midframe_bit3", 32'(st()), 32'(5'b01000));
        rst = 1'b1;
        tick();
        check("midframe_reset", 32'(st()), 32'(5'b10100));
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (st() !== 5'b10100) bad++;
        end
        check("midframe_quiet_bad", 32'(bad), 32'd0);
        check("midframe_no_frames", 32'(rx_q.size()), 32'd0);
        write_byte(8'hC3);
        wait_rx(1, 60);
        if (rx_q.size() >= 1) check("after_reset_byte", 32'(rx_q[0].data), 32'hC3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
